// File: rtl/sm_subtractor_pipe_pkg.sv
// sm_pkg: sign-magnitude word format shared by the adder and subtractor datapaths
package sm_pkg;
  localparam int SM_W = 16;
  typedef struct packed {
    logic            sign;
    logic [SM_W-2:0] mag;
  } sm_t;
  function automatic sm_t sm_canon(sm_t x);
    sm_t r;
    r.sign = x.sign & (|x.mag);
    r.mag  = x.mag;
    return r;
  endfunction
endpackage

// File: rtl/sm_subtractor_pipe_if.sv
// sm_subtractor_pipe_if: operand/result valid-ready bundle for the subtractor
interface sm_subtractor_pipe_if import sm_pkg::*; #(parameter int W = SM_W);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         ovf;
  modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, diff, ovf);
  modport slave (input in_valid, a, b, out_ready, output in_ready, out_valid, diff, ovf);
endinterface

// File: rtl/sm_subtractor_pipe_mag_addsub.sv
// sm_mag_addsub: magnitude add (with carry) or larger-minus-smaller subtract
module sm_mag_addsub #(parameter int MW = 15) (
  input  logic [MW-1:0] ma_i,
  input  logic [MW-1:0] mb_i,
  input  logic          op_i,
  input  logic          agt_i,
  output logic [MW-1:0] mag_o,
  output logic          carry_o
);
  always_comb {carry_o, mag_o} = op_i ? {1'b0, ma_i} + {1'b0, mb_i} : {1'b0, agt_i ? ma_i - mb_i : mb_i - ma_i};
endmodule

// File: rtl/sm_subtractor_pipe.sv
// sm_subtractor_pipe: two-stage sign-magnitude A - B with valid/ready backpressure
module sm_subtractor_pipe import sm_pkg::*; #(parameter int W = SM_W) (
  input logic                clk,
  input logic                rst_n,
  sm_subtractor_pipe_if.slave io
);
  logic         s1_valid_q, s2_valid_q, sa_q, sb_q, eq_q, agt_q;
  logic [W-2:0] ma_q, mb_q, mag;
  logic         carry, s1_en, s2_en, add, ovf_q, ovf_d;
  sm_t          diff_q, diff_d, raw;
  assign s2_en       = !s2_valid_q | io.out_ready;
  assign s1_en       = !s1_valid_q | s2_en;
  assign io.in_ready = s1_en & rst_n;
  assign add         = sa_q == sb_q;
  sm_mag_addsub #(.MW(W-1)) u_mag (
    .ma_i(ma_q), .mb_i(mb_q), .op_i(add), .agt_i(agt_q), .mag_o(mag), .carry_o(carry)
  );
  // equal magnitudes with differing signs cancel to +0
  always_comb begin
    raw.sign = (add | agt_q) ? sa_q : (!eq_q & sb_q);
    raw.mag  = mag;
    diff_d   = sm_canon(raw);
    ovf_d    = add & carry;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      diff_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (s1_en) s1_valid_q <= io.in_valid;
      if (io.in_valid & s1_en) begin
        sa_q  <= io.a[W-1];
        sb_q  <= ~io.b[W-1];
        ma_q  <= io.a[W-2:0];
        mb_q  <= io.b[W-2:0];
        eq_q  <= io.a[W-2:0] == io.b[W-2:0];
        agt_q <= io.a[W-2:0] > io.b[W-2:0];
      end
      if (s2_en) s2_valid_q <= s1_valid_q;
      if (s1_valid_q & s2_en) begin
        diff_q <= diff_d;
        ovf_q  <= ovf_d;
      end
    end
  end
  assign io.out_valid = s2_valid_q;
  assign io.diff      = diff_q;
  assign io.ovf       = ovf_q;
endmodule

// File: tb/tb_sm_subtractor_pipe.sv
// tb_sm_subtractor_pipe: directed and reference-model checks of the pipelined subtractor
module tb_sm_subtractor_pipe;
  import sm_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  sm_subtractor_pipe_if #(.W(16)) io ();
  sm_subtractor_pipe #(.W(16)) dut (.clk(clk), .rst_n(rst_n), .io(io));
  int passed = 0;
  int total = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else passed++;
  endtask
  function automatic logic [16:0] ref_sub(input logic [15:0] a, input logic [15:0] b);
    int va, vb, r, m;
    logic [14:0] mw;
    va = a[15] ? -int'(a[14:0]) : int'(a[14:0]);
    vb = b[15] ? -int'(b[14:0]) : int'(b[14:0]);
    r  = va - vb;
    m  = r < 0 ? -r : r;
    mw = m[14:0];
    return {m > 32767, (r < 0) && (mw != 15'd0), mw};
  endfunction
  task automatic run_one(input int i, input logic [15:0] a, input logic [15:0] b, input logic [15:0] ed, input logic eo);
    io.a = a;
    io.b = b;
    io.in_valid = 1'b1;
    io.out_ready = 1'b1;
    #1 check($sformatf("vec%0d in_ready", i), io.in_ready, 1);
    @(negedge clk);
    io.in_valid = 1'b0;
    check($sformatf("vec%0d lat1 out_valid", i), io.out_valid, 0);
    @(negedge clk);
    check($sformatf("vec%0d lat2 out_valid", i), io.out_valid, 1);
    check($sformatf("vec%0d diff", i), io.diff, ed);
    check($sformatf("vec%0d ovf", i), io.ovf, eo);
  endtask
  logic [15:0] va[8] = '{16'h0005, 16'h0003, 16'h8003, 16'h0003, 16'h8004, 16'h7FFF, 16'h7FFF, 16'h8000};
  logic [15:0] vb[8] = '{16'h0003, 16'h0005, 16'h0005, 16'h8005, 16'h8004, 16'h8001, 16'h8002, 16'h0000};
  logic [15:0] vd[8] = '{16'h0002, 16'h8002, 16'h8008, 16'h0008, 16'h0000, 16'h0000, 16'h0001, 16'h0000};
  logic        vo[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [15:0] bpa[4] = '{16'h000A, 16'h8001, 16'h0002, 16'h0100};
  logic [15:0] bpb[4] = '{16'h0003, 16'h0001, 16'h0009, 16'h8100};
  logic [15:0] bpe[4] = '{16'h0007, 16'h8002, 16'h8007, 16'h0200};
  logic [15:0] ta[100], tb_b[100];
  initial begin
    int sent, recv;
    logic hold, in_fire;
    logic [15:0] prev;
    logic [16:0] e;
    io.in_valid = 1'b0;
    io.a = '0;
    io.b = '0;
    io.out_ready = 1'b0;
    @(negedge clk);
    check("rst out_valid", io.out_valid, 0);
    check("rst diff", io.diff, 0);
    check("rst ovf", io.ovf, 0);
    check("rst in_ready", io.in_ready, 0);
    rst_n = 1'b1;
    #1 check("rst release in_ready", io.in_ready, 1);
    @(negedge clk);
    for (int i = 0; i < 8; i++) run_one(i, va[i], vb[i], vd[i], vo[i]);
    @(negedge clk);
    sent = 0;
    recv = 0;
    hold = 1'b0;
    prev = '0;
    for (int k = 0; k < 40 && recv < 4; k++) begin
      io.out_ready = k >= 3;
      io.in_valid = sent < 4;
      io.a = bpa[sent % 4];
      io.b = bpb[sent % 4];
      #1;
      if (k == 2) begin
        check("bp in_ready full", io.in_ready, 0);
        check("bp accepted before full", sent, 2);
      end
      if (hold) check("bp diff hold", io.diff, prev);
      in_fire = io.in_valid & io.in_ready;
      if (io.out_valid & io.out_ready) begin
        check($sformatf("bp out%0d diff", recv), io.diff, bpe[recv % 4]);
        check($sformatf("bp out%0d ovf", recv), io.ovf, 0);
        recv++;
      end
      hold = io.out_valid & !io.out_ready;
      prev = io.diff;
      if (in_fire) sent++;
      @(negedge clk);
    end
    io.in_valid = 1'b0;
    check("bp result count", recv, 4);
    #1 check("bp no duplicate", io.out_valid, 0);
    @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      ta[i] = 16'($urandom);
      tb_b[i] = 16'($urandom);
      if (i % 10 == 0) ta[i] = 16'h8000;
      if (i % 7 == 0) begin
        ta[i] = {1'b0, 15'h7F00 | 15'($urandom_range(0, 255))};
        tb_b[i] = {1'b1, 15'h7F00 | 15'($urandom_range(0, 255))};
      end
    end
    io.out_ready = 1'b1;
    for (int k = 0; k < 102; k++) begin
      io.in_valid = k < 100;
      io.a = ta[k % 100];
      io.b = tb_b[k % 100];
      #1;
      if (k < 100) check($sformatf("tp%0d in_ready", k), io.in_ready, 1);
      if (k >= 2) begin
        e = ref_sub(ta[k-2], tb_b[k-2]);
        check($sformatf("tp%0d out_valid", k - 2), io.out_valid, 1);
        check($sformatf("tp%0d diff", k - 2), io.diff, e[15:0]);
        check($sformatf("tp%0d ovf", k - 2), io.ovf, e[16]);
      end
      @(negedge clk);
    end
    io.in_valid = 1'b0;
    @(negedge clk);
    io.out_ready = 1'b0;
    io.in_valid = 1'b1;
    io.a = 16'h7FFF;
    io.b = 16'h8002;
    @(negedge clk);
    io.a = 16'h0020;
    io.b = 16'h0001;
    @(negedge clk);
    io.in_valid = 1'b0;
    check("mid pre-reset out_valid", io.out_valid, 1);
    check("mid pre-reset ovf", io.ovf, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid rst out_valid", io.out_valid, 0);
    check("mid rst diff", io.diff, 0);
    check("mid rst ovf", io.ovf, 0);
    check("mid rst in_ready", io.in_ready, 0);
    rst_n = 1'b1;
    io.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("mid stale%0d out_valid", k), io.out_valid, 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
